// File: rtl/mc_riscv_controller_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states, opcodes,
// ALU operation codes, immediate formats and the per-state control word.
package mc_riscv_controller_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_riscv_controller_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus funct fields to the ALU operation.
module mc_riscv_controller_alu_decoder
  import mc_riscv_controller_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB:  alu_control_o = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3_i)
          // op[5] separates R-type sub from addi, whose funct7 bit is immediate data
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default:    alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_riscv_controller.sv
// Moore FSM sequencing a shared-memory, shared-ALU RISC-V datapath over 2-5 cycles
// per instruction (lw, sw, R/I ALU, beq, jal).
module mc_riscv_controller
  import mc_riscv_controller_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic               RegWrite,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0] state_q, state_d, cur_s;
  logic               bad_op;
  ctrl_t              ctl;

  // Reset presents FETCH decode immediately, before the state register is loaded
  assign cur_s = rst ? STATE_W'(S_FETCH) : state_q;

  always_comb begin
    state_d = STATE_W'(S_FETCH);
    bad_op  = 1'b0;
    case (cur_s)
      STATE_W'(S_FETCH):  state_d = STATE_W'(S_DECODE);
      STATE_W'(S_DECODE): begin
        case (op)
          OP_LW, OP_SW: state_d = STATE_W'(S_MEMADR);
          OP_R:         state_d = STATE_W'(S_EXECUTER);
          OP_I:         state_d = STATE_W'(S_EXECUTEI);
          OP_BEQ:       state_d = STATE_W'(S_BEQ);
          OP_JAL:       state_d = STATE_W'(S_JAL);
          default: begin
            state_d = STATE_W'(S_FETCH);
            bad_op  = 1'b1;
          end
        endcase
      end
      STATE_W'(S_MEMADR):   state_d = op[5] ? STATE_W'(S_MEMWRITE) : STATE_W'(S_MEMREAD);
      STATE_W'(S_MEMREAD):  state_d = STATE_W'(S_MEMWB);
      STATE_W'(S_EXECUTER),
      STATE_W'(S_EXECUTEI),
      STATE_W'(S_JAL):      state_d = STATE_W'(S_ALUWB);
      default:              state_d = STATE_W'(S_FETCH);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= STATE_W'(S_FETCH);
    else     state_q <= state_d;
  end

  always_comb begin
    ctl = '0;
    case (cur_s)
      STATE_W'(S_FETCH): begin
        ctl.ir_write   = 1'b1;
        ctl.pc_update  = 1'b1;
        ctl.alu_src_b  = 2'b10;
        ctl.result_src = 2'b10;
      end
      STATE_W'(S_DECODE): begin
        ctl.alu_src_a = 2'b01;
        ctl.alu_src_b = 2'b01;
      end
      STATE_W'(S_MEMADR): begin
        ctl.alu_src_a = 2'b10;
        ctl.alu_src_b = 2'b01;
      end
      STATE_W'(S_MEMREAD):  ctl.adr_src = 1'b1;
      STATE_W'(S_MEMWB): begin
        ctl.result_src = 2'b01;
        ctl.reg_write  = 1'b1;
      end
      STATE_W'(S_MEMWRITE): begin
        ctl.adr_src   = 1'b1;
        ctl.mem_write = 1'b1;
      end
      STATE_W'(S_EXECUTER): begin
        ctl.alu_src_a = 2'b10;
        ctl.alu_op    = ALUOP_FUNC;
      end
      STATE_W'(S_EXECUTEI): begin
        ctl.alu_src_a = 2'b10;
        ctl.alu_src_b = 2'b01;
        ctl.alu_op    = ALUOP_FUNC;
      end
      STATE_W'(S_ALUWB):    ctl.reg_write = 1'b1;
      STATE_W'(S_BEQ): begin
        ctl.alu_src_a = 2'b10;
        ctl.alu_op    = ALUOP_SUB;
        ctl.branch    = 1'b1;
      end
      STATE_W'(S_JAL): begin
        ctl.alu_src_a = 2'b01;
        ctl.alu_src_b = 2'b10;
        ctl.pc_update = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  mc_riscv_controller_alu_decoder u_alu_dec (
    .alu_op_i      (ctl.alu_op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .op5_i         (op[5]),
    .alu_control_o (ALUControl)
  );

  // Enables are gated by rst so a reset landing mid-instruction cannot write anything
  assign PCWrite   = ~rst & (ctl.pc_update | (ctl.branch & zero));
  assign MemWrite  = ~rst & ctl.mem_write;
  assign IRWrite   = ~rst & ctl.ir_write;
  assign RegWrite  = ~rst & ctl.reg_write;
  assign illegal   = ~rst & bad_op;
  assign AdrSrc    = ctl.adr_src;
  assign ResultSrc = ctl.result_src;
  assign ALUSrcA   = ctl.alu_src_a;
  assign ALUSrcB   = ctl.alu_src_b;
  assign ImmSrc    = imm_src_of(op);
  assign state     = cur_s;

endmodule

// File: doc/mc_riscv_controller.md
Name: mc_riscv_controller

Overview:
Multicycle control unit for the RISC-V core. It replaces the hand-driven ImmSRC/ALUSrc/ResultSrc strapping of the single-cycle bench with a Moore FSM that sequences a shared-memory, shared-ALU datapath over 3–5 cycles per instruction. It supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal. It sits beside the datapath and consumes op/funct fields from the instruction register plus the ALU zero flag.

Parameters:
STATE_W, 4, width of state register / debug state output

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
op  input  7  instr[6:0] from IR
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag
PCWrite  output  1  PC load enable
AdrSrc  output  1  memory address select: 0=PC, 1=ALU result register
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register load enable
ResultSrc  output  2  00=ALUOut reg, 01=Data reg, 10=ALU result
ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1 reg
ALUSrcB  output  2  00=RD2 reg, 01=ImmExt, 10=const 4
ImmSrc  output  2  00=I, 01=S, 10=B, 11=J
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
RegWrite  output  1  register file write enable
illegal  output  1  one-cycle pulse, unsupported opcode decoded
state  output  STATE_W  current state (debug)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high. On a clk edge with rst=1, state <= FETCH (0). While rst=1, PCWrite, MemWrite, IRWrite, RegWrite and illegal are forced to 0. All other outputs show FETCH decode values.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10. Unused encodings go to FETCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other op -> FETCH with illegal=1 for that cycle.
  - MEMADR -> MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER, EXECUTEI, JAL -> ALUWB -> FETCH.
  - BEQ -> FETCH.
- Moore outputs (all unlisted enables are 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- PCWrite = PCUpdate | (Branch & zero); combinational, same cycle.
- ImmSrc: purely combinational from op, independent of state. Store -> 01, branch -> 10, jal -> 11, else 00.
- ALU decode:
  - ALUOp 00 -> add; 01 -> sub.
  - ALUOp 10 by funct3: 000 -> sub iff op[5] & funct7b5, else add; 010 -> slt; 110 -> or; 111 -> and; other funct3 -> add.
- Latency in cycles (including FETCH): lw 5, sw 4, R/I/jal 4, beq 3, illegal 2.
- Reset asserted mid-instruction: the next edge forces FETCH. Enables are low during the reset cycle, so no partial MemWrite/RegWrite.

Decomposition:
- Shared package/header riscv_ctrl_defs: state encodings, opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL), ALUControl and ALUOp codes, ImmSrc codes.
- One sub-module, alu_decoder (combinational): ALUOp, funct3, funct7b5, op[5] -> ALUControl.

Test Plan:
- Reset: hold rst=1 for 5 edges with op=0000011 -> state=0, IRWrite=0, PCWrite=0, RegWrite=0. Release -> state sequence 0,1,2,3,4,0. RegWrite=1 only in state 4, with ResultSrc=01.
- sw: op=0100011 -> states 0,1,2,5,0. MemWrite=1 only in state 5, AdrSrc=1, ImmSrc=01 throughout.
- R-type sub vs add: op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in EXECUTER. Same with op=0010011 (addi), funct7b5=1 -> ALUControl=000. funct3=010 -> 101.
- beq: op=1100011, zero=1 -> PCWrite=1 in BEQ, state back to 0 next cycle. Repeat with zero=0 -> PCWrite=0 in BEQ.
- jal: op=1101111 -> states 0,1,10,8,0. PCWrite=1 in JAL, ImmSrc=11, RegWrite=1 in ALUWB.
- Illegal/reset mid-op: op=1111111 -> DECODE pulses illegal=1, then FETCH. Assert rst in MEMWRITE -> MemWrite=0 that cycle, state=0 next edge.
